tpmem_pingpong: RTL and testbench
=================================

# tpmem_pingpong

Parametrised N×N transpose buffer with ping-pong double banking and valid/ready handshakes on both sides. Rows of one block are written into one bank while the previous block drains column-by-column from the other bank, so a continuous stream runs at one beat per cycle. The block sits between row-oriented and column-oriented processing stages in the 2-D transform datapath. A per-block mode selects transpose or row pass-through.

## Interface
- BW, 12, element width in bits
- N, 8, block dimension (rows = columns = beats per block); power of two, 2..16
- i_clk  input  1  clock, all logic on rising edge
- i_Reset  input  1  synchronous reset, active-high
- i_data  input  N*BW  one input row; element c at bits [(N-c)*BW-1 -: BW] (element 0 at MSB)
- i_valid  input  1  i_data valid
- i_mode  input  1  0 = transpose, 1 = pass-through; sampled with row 0 of each block
- o_ready  output  1  block can accept a row this cycle
- o_data  output  N*BW  one output beat, same element packing as i_data
- o_valid  output  1  o_data valid
- i_ready  input  1  downstream accepts o_data this cycle

## Operation
- State: two banks B0/B1 of N rows × N*BW; full flags f0/f1; per-bank mode bit m0/m1; wr_sel, rd_sel (1 bit); wr_cnt, rd_cnt (log2 N bits).
- o_ready = ~f[wr_sel] & ~i_Reset (combinational).
- Write accept (i_valid & o_ready): B[wr_sel] row wr_cnt <= i_data; if wr_cnt==0, m[wr_sel] <= i_mode; wr_cnt++. On wr_cnt==N-1: f[wr_sel] <= 1, wr_sel toggles, wr_cnt <= 0.
- Output load condition: f[rd_sel] & (~o_valid | i_ready).
- On load: transpose mode → o_data <= column rd_cnt, i.e. element r = B[rd_sel][r][rd_cnt]. Pass-through → o_data <= row rd_cnt unchanged. o_valid <= 1; rd_cnt++. On rd_cnt==N-1: f[rd_sel] <= 0, rd_sel toggles, rd_cnt <= 0.
- If no load and i_ready: o_valid <= 0. If o_valid & ~i_ready: o_data and o_valid hold.
- Boundaries:
  - Writer never targets a full bank, so set/clear of the same flag in one cycle cannot occur. Set of one flag and clear of the other in the same cycle both apply.
  - Both banks full → o_ready low until a bank frees.
  - Counters wrap N-1 → 0 only via the block-end rule.
  - i_mode outside row 0 of a block is ignored.
  - i_valid with o_ready low: row not taken, no state change.
- Reset (including mid-block): f0=f1=0, wr_sel=rd_sel=0, wr_cnt=rd_cnt=0, m0=m1=0, o_valid=0, o_data=0. Partial and pending blocks are discarded. Bank contents need not be cleared because they are unobservable.

## Timing
- Reset values: o_valid 0, o_data 0, o_ready 0 while i_Reset high; o_ready 1 the first cycle after reset deasserts.
- Latency: last row of a block accepted at edge t → first output beat registered at edge t+1 (o_valid high in cycle after t+1 edge), provided the output register is free.
- Throughput: with i_valid=i_ready=1 continuously, o_ready never drops. The output stream is gap-free: N beats per block.
- Bank freed at the edge loading its beat N-1; writer may reuse it in the following cycle.
- o_data is registered; no combinational path from i_data to o_data. i_ready→o_ready path is registered (through f).

## Test plan
- N=8, BW=12, single block, element (r,c)=16r+c, mode 0: 8 rows in cycles 0..7 → o_valid rises after edge 8. Beat k element r = 16r+k. Then o_valid=0.
- Four back-to-back blocks, i_ready=1, block b element = 256b+16r+c → o_ready stays 1 throughout. 32 contiguous beats, correct transposes in order.
- i_ready=0 while streaming: after 16 accepted rows o_ready=0 and beat 0 of block 0 holds stable. Raise i_ready → all 16 beats emitted exactly once in order, o_ready returns 1 after block 0's beat 7 loads.
- Mode mix: block0 mode 0, block1 i_mode=1 on row 0 then toggled on rows 1..7 → block1 output equals its input rows unchanged. Block0 transposed.
- Reset after 5 rows of a block (1-cycle i_Reset) → o_valid 0, o_data 0. Next full block outputs only its own data, no stale rows.
- N=4, BW=8, mode 0 stream of 3 blocks with random i_valid/i_ready toggling → outputs match reference transpose model, no loss or duplication.

Source files
------------

// File: rtl/tpmem_pingpong_if.sv
// Row-in / beat-out streaming bus of the transpose buffer.
// The master side supplies rows and downstream ready; the slave side is the buffer.
interface tpmem_pingpong_if #(
    parameter int BW = 12,
    parameter int N  = 8
);
    logic [N*BW-1:0] i_data;
    logic            i_valid;
    logic            i_mode;
    logic            o_ready;
    logic [N*BW-1:0] o_data;
    logic            o_valid;
    logic            i_ready;

    modport slave  (input  i_data, i_valid, i_mode, i_ready,
                    output o_ready, o_data, o_valid);
    modport master (output i_data, i_valid, i_mode, i_ready,
                    input  o_ready, o_data, o_valid);
endinterface

// File: rtl/tpmem_pingpong.sv
// N x N transpose buffer with two ping-pong banks.
// Rows of one block fill one bank while the other bank drains column by column
// (or row by row in pass-through mode), giving one beat per cycle when streaming.
module tpmem_pingpong #(
    parameter int BW = 12,
    parameter int N  = 8
) (
    input  logic             i_clk,
    input  logic             i_Reset,
    tpmem_pingpong_if.slave  bus
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    // element 0 sits in the top slot, so element c of a row is index N-1-c
    typedef logic [N-1:0][BW-1:0] row_t;

    row_t            mem [2][N];
    logic [1:0]      full;
    logic [1:0]      mode;
    logic            wr_sel, rd_sel;
    logic [AW-1:0]   wr_cnt, rd_cnt;
    row_t            o_data_q;
    logic            o_valid_q;

    logic            wr_acc, rd_load;
    row_t            col_beat, row_beat;

    assign bus.o_ready = ~full[wr_sel] & ~i_Reset;
    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;

    assign wr_acc  = bus.i_valid & bus.o_ready;
    assign rd_load = full[rd_sel] & (~o_valid_q | bus.i_ready);

    // pass-through beat is the stored row itself
    assign row_beat = mem[rd_sel][rd_cnt];

    // column gather: output element r comes from row r, element rd_cnt.
    // Element rd_cnt lives at index N-1-rd_cnt, which is ~rd_cnt since N is a power of two.
    for (genvar r = 0; r < N; r++) begin : g_col
        assign col_beat[N-1-r] = mem[rd_sel][r][~rd_cnt];
    end

    // bank storage: accepted row goes to the write bank at the current row slot
    always_ff @(posedge i_clk) begin
        if (wr_acc)
            mem[wr_sel][wr_cnt] <= bus.i_data;
    end

    // write/read sequencing, bank flags and the registered output stage
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            full      <= '0;
            mode      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            if (wr_acc) begin
                if (wr_cnt == '0)
                    mode[wr_sel] <= bus.i_mode;
                if (wr_cnt == LAST) begin
                    // writer never targets a full bank, so this cannot collide
                    // with the read side clearing the same flag
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                    wr_cnt       <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rd_load) begin
                o_data_q  <= mode[rd_sel] ? row_beat : col_beat;
                o_valid_q <= 1'b1;
                if (rd_cnt == LAST) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                    rd_cnt       <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end else if (bus.i_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tpmem_pingpong.sv
// Directed bench for tpmem_pingpong: an N=8/BW=12 instance for the block-level
// scenarios and an N=4/BW=8 instance for a randomly throttled stream.
module tb_tpmem_pingpong;
    localparam int BW8 = 12, N8 = 8, W8 = N8*BW8;
    localparam int BW4 = 8,  N4 = 4, W4 = N4*BW4;

    logic i_clk   = 1'b0;
    logic i_Reset = 1'b1;
    always #5 i_clk = ~i_clk;

    tpmem_pingpong_if #(.BW(BW8), .N(N8)) b8();
    tpmem_pingpong_if #(.BW(BW4), .N(N4)) b4();

    tpmem_pingpong #(.BW(BW8), .N(N8)) u8 (.i_clk(i_clk), .i_Reset(i_Reset), .bus(b8.slave));
    tpmem_pingpong #(.BW(BW4), .N(N4)) u4 (.i_clk(i_clk), .i_Reset(i_Reset), .bus(b4.slave));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall8 = 0;
    logic [W8-1:0] cap8[$];
    int            capcyc8[$];
    logic [W4-1:0] cap4[$];

    // cycle counter for beat contiguity
    always @(posedge i_clk) cyc <= cyc + 1;

    // capture every beat that is handed downstream at the coming edge
    always @(negedge i_clk) begin
        if (b8.o_valid === 1'b1 && b8.i_ready === 1'b1) begin
            cap8.push_back(b8.o_data);
            capcyc8.push_back(cyc);
        end
        if (b4.o_valid === 1'b1 && b4.i_ready === 1'b1)
            cap4.push_back(b4.o_data);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W8-1:0] row8(input int base, input int r);
        logic [W8-1:0] v;
        for (int c = 0; c < N8; c++) v[(N8-c)*BW8-1 -: BW8] = BW8'(base + 16*r + c);
        return v;
    endfunction

    function automatic logic [W8-1:0] col8(input int base, input int k);
        logic [W8-1:0] v;
        for (int r = 0; r < N8; r++) v[(N8-r)*BW8-1 -: BW8] = BW8'(base + 16*r + k);
        return v;
    endfunction

    function automatic logic [W4-1:0] row4(input int base, input int r);
        logic [W4-1:0] v;
        for (int c = 0; c < N4; c++) v[(N4-c)*BW4-1 -: BW4] = BW4'(base + 16*r + c);
        return v;
    endfunction

    function automatic logic [W4-1:0] col4(input int base, input int k);
        logic [W4-1:0] v;
        for (int r = 0; r < N4; r++) v[(N4-r)*BW4-1 -: BW4] = BW4'(base + 16*r + k);
        return v;
    endfunction

    // all drive tasks are entered and left 1 time unit after a rising edge
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send8(input logic [W8-1:0] d, input logic m);
        int w;
        w = 0;
        b8.i_data = d; b8.i_mode = m; b8.i_valid = 1'b1;
        @(negedge i_clk);
        while (!b8.o_ready && w < 300) begin
            w++; stall8++;
            @(negedge i_clk);
        end
        if (!b8.o_ready) chk("send8_timeout", b8.o_ready, 1'b1);
        @(posedge i_clk); #1;
        b8.i_valid = 1'b0;
    endtask

    task automatic send4(input logic [W4-1:0] d);
        int w;
        w = 0;
        b4.i_data = d; b4.i_mode = 1'b0; b4.i_valid = 1'b1;
        @(negedge i_clk);
        while (!b4.o_ready && w < 300) begin
            w++;
            @(negedge i_clk);
        end
        if (!b4.o_ready) chk("send4_timeout", b4.o_ready, 1'b1);
        @(posedge i_clk); #1;
        b4.i_valid = 1'b0;
    endtask

    // mpat 0: mode 0 on every row; mpat 1: mode 1 on row 0, then alternating
    task automatic block8(input int base, input int mpat);
        for (int r = 0; r < N8; r++)
            send8(row8(base, r), (mpat == 1) ? (r % 2 == 0) : 1'b0);
    endtask

    function automatic logic [W8-1:0] capat8(input int k);
        return (k < cap8.size()) ? cap8[k] : 'x;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        b8.i_data = '0; b8.i_valid = 1'b0; b8.i_mode = 1'b0; b8.i_ready = 1'b0;
        b4.i_data = '0; b4.i_valid = 1'b0; b4.i_mode = 1'b0; b4.i_ready = 1'b0;

        // reset state
        i_Reset = 1'b1;
        wait_cyc(3);
        @(negedge i_clk);
        chk("rst_ovalid", b8.o_valid, 1'b0);
        chk("rst_odata",  b8.o_data, '0);
        chk("rst_oready", b8.o_ready, 1'b0);
        @(posedge i_clk); #1;
        i_Reset = 1'b0;
        @(negedge i_clk);
        chk("rel_oready", b8.o_ready, 1'b1);
        @(posedge i_clk); #1;

        // single block, transpose, latency
        b8.i_ready = 1'b1;
        cap8.delete();
        block8(0, 0);
        @(negedge i_clk);
        chk("t1_lat_pre", b8.o_valid, 1'b0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("t1_lat_vld", b8.o_valid, 1'b1);
        chk("t1_lat_dat", b8.o_data, col8(0, 0));
        wait_cyc(12);
        chk("t1_count", cap8.size(), 8);
        for (int k = 0; k < N8; k++) chk($sformatf("t1_beat%0d", k), capat8(k), col8(0, k));
        @(negedge i_clk);
        chk("t1_idle", b8.o_valid, 1'b0);
        @(posedge i_clk); #1;

        // four back-to-back blocks, no stalls, gap-free output
        cap8.delete(); capcyc8.delete(); stall8 = 0;
        for (int b = 0; b < 4; b++) block8(256*b, 0);
        wait_cyc(20);
        chk("t2_stalls", stall8, 0);
        chk("t2_count", cap8.size(), 32);
        if (capcyc8.size() == 32) chk("t2_contig", capcyc8[31] - capcyc8[0], 31);
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < N8; k++)
                chk($sformatf("t2_b%0d_beat%0d", b, k), capat8(8*b + k), col8(256*b, k));

        // downstream stalled while two blocks arrive
        b8.i_ready = 1'b0;
        cap8.delete();
        block8(0, 0);
        block8(256, 0);
        @(negedge i_clk);
        chk("t3_oready_lo", b8.o_ready, 1'b0);
        chk("t3_vld", b8.o_valid, 1'b1);
        chk("t3_hold_a", b8.o_data, col8(0, 0));
        wait_cyc(3);
        @(negedge i_clk);
        chk("t3_hold_b", b8.o_data, col8(0, 0));
        chk("t3_none", cap8.size(), 0);
        @(posedge i_clk); #1;
        b8.i_ready = 1'b1;
        repeat (6) @(posedge i_clk);
        @(negedge i_clk);
        chk("t3_oready_b6", b8.o_ready, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("t3_oready_b7", b8.o_ready, 1'b1);
        wait_cyc(12);
        chk("t3_count", cap8.size(), 16);
        for (int k = 0; k < 16; k++)
            chk($sformatf("t3_beat%0d", k), capat8(k), col8(256*(k/8), k%8));

        // mode mix: transpose then pass-through with noisy i_mode on rows 1..7
        cap8.delete();
        block8(0, 0);
        block8(256, 1);
        wait_cyc(20);
        chk("t4_count", cap8.size(), 16);
        for (int k = 0; k < N8; k++) chk($sformatf("t4_tr%0d", k), capat8(k), col8(0, k));
        for (int k = 0; k < N8; k++) chk($sformatf("t4_pt%0d", k), capat8(8 + k), row8(256, k));

        // reset in the middle of a block discards it
        for (int r = 0; r < 5; r++) send8(row8(768, r), 1'b1);
        i_Reset = 1'b1;
        @(posedge i_clk); #1;
        i_Reset = 1'b0;
        @(negedge i_clk);
        chk("t5_ovalid", b8.o_valid, 1'b0);
        chk("t5_odata", b8.o_data, '0);
        chk("t5_oready", b8.o_ready, 1'b1);
        @(posedge i_clk); #1;
        cap8.delete();
        block8(512, 0);
        wait_cyc(20);
        chk("t5_count", cap8.size(), 8);
        for (int k = 0; k < N8; k++) chk($sformatf("t5_beat%0d", k), capat8(k), col8(512, k));

        // N=4 stream with random valid/ready throttling
        cap4.delete();
        fork
            begin
                for (int b = 0; b < 3; b++)
                    for (int r = 0; r < N4; r++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
                        send4(row4(64*b, r));
                    end
            end
            begin
                int t;
                t = 0;
                while (cap4.size() < 12 && t < 3000) begin
                    b4.i_ready = 1'($urandom_range(0, 1));
                    @(posedge i_clk); #1;
                    t++;
                end
                b4.i_ready = 1'b1;
            end
        join
        wait_cyc(10);
        chk("t6_count", cap4.size(), 12);
        for (int k = 0; k < 12; k++)
            chk($sformatf("t6_beat%0d", k), (k < cap4.size()) ? cap4[k] : 'x, col4(64*(k/4), k%4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
